network_controller: RTL and testbench
=====================================

# network_controller

Consumes the weight-write stream produced by the ROM controller (`writeData`, `address`, `rom_output`) and holds four signed weights in a register bank. When `start_network_controller` pulses, it runs a four-cycle multiply-accumulate of the weights against four latched 8-bit inputs. It then emits a 26-bit signed neuron sum and a threshold-fire bit. It is the receiving end of the ROM load interface and the first compute stage of the network.

## Interface

Parameters:
- THRESHOLD, 0: signed 26-bit firing threshold; `fire` = (result > THRESHOLD), signed compare.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- writeData  input  1  weight write strobe, sampled on the rising edge.
- address  input  [1:0]  weight index 0..3 for the write.
- rom_output  input  [0:31]  write data word. Bits [16:31] are the signed 16-bit weight, bit 16 is the MSB. Bits [0:15] are ignored.
- start_network_controller  input  1  compute request, level sampled on each edge.
- inputs  input  [0:31]  four signed 8-bit inputs; x_k = inputs[8k:8k+7], bit 8k is the MSB.
- busy  output  1  high while in the MAC state.
- done  output  1  one-cycle pulse; `result` and `fire` update on the same edge.
- result  output  [0:25]  signed neuron sum; bit 0 is the MSB.
- fire  output  1  result > THRESHOLD.
- loaded  output  [3:0]  per-weight "written since reset" flags; bit k = weight k.
- err  output  1  one-cycle pulse when a start is rejected.

## Operation

- States: IDLE, MAC, DONE.
- Weight writes:
  - Accepted only in IDLE or DONE. On an accepted write, weight[address] ← rom_output[16:31] and loaded[address] ← 1.
  - Writes in MAC are ignored: no weight change, no flag change.
- Start in IDLE or DONE:
  - If loaded == 4'b1111: latch `inputs` into an internal register, clear the accumulator, set k=0, go to MAC.
  - Otherwise: pulse err, stay or return to IDLE.
- Start while in MAC is ignored. err is not raised.
- Write and start on the same edge in IDLE: the write lands, and its new loaded bit counts toward the start check. The MAC uses the new weight.
- MAC: each edge adds sext(weight[k]) × sext(x_k) to the accumulator, then k increments. The edge with k=3 transitions to DONE.
- Arithmetic:
  - Each product is a 16×8 signed multiply into 24 bits.
  - The accumulator is 26-bit signed; four products cannot overflow.
  - No saturation and no rounding.
- DONE lasts one cycle, then goes to IDLE unless a valid start is present. DONE accepts a new start exactly as IDLE does.
- result and fire hold their values until the next completed MAC.
- Reset, asynchronous and any time including mid-MAC:
  - State → IDLE; all weights, accumulator and k → 0.
  - Outputs: busy=0, done=0, result=0, fire=0, loaded=4'b0000, err=0.
  - The interrupted computation is discarded.

## Timing

- Valid start sampled at edge E0: busy=1 after E0. Products 0..3 are added at E1..E4.
- At E4: result and fire update, done=1 and busy=0, held for the cycle between E4 and E5.
- Start-to-done latency is 4 clocks. A back-to-back start sampled at E5 gives a throughput of one result per 5 clocks.
- `inputs` is don't-care after E0.
- Weight write-to-use: a write at edge En is usable by a start sampled at En or later.
- err pulses for exactly one cycle after the rejecting edge.
- done is never asserted without a preceding accepted start.

## Test plan

1. **Basic MAC.**
   - Stimulus: reset; write weights 0x0001, 0x0002, 0x0003, 0x0004 to addresses 0..3; inputs=0x01010101; pulse start.
   - Required: loaded=4'b1111; busy for 4 cycles; done 4 clocks after start; result=10; fire=1 with THRESHOLD=0.
2. **Negative sum.**
   - Stimulus: all weights 0xFFFF (−1); inputs=0x7F7F7F7F.
   - Required: result=−508 (26'h3FFFE04); fire=0.
3. **Extreme operands.**
   - Stimulus: all weights 0x8000; inputs=0x80808080.
   - Required: result=16777216 (26'h1000000); no overflow.
4. **Incomplete load.**
   - Stimulus: write only addresses 0..2; pulse start.
   - Required: err one-cycle pulse; busy stays 0; done never asserted; result unchanged.
5. **Write during MAC.**
   - Stimulus: mid-MAC write of 0x7FFF to address 1.
   - Required: current result uses the old weight; a following start also uses the old weight, since the write was dropped.
   - Also: a start pulse issued during MAC produces no extra done.
6. **Reset mid-MAC.**
   - Stimulus: assert reset two cycles after start.
   - Required: busy, done, result, fire and err read 0 immediately; loaded=4'b0000; a subsequent start raises err.

Source files
------------

// File: rtl/network_controller_if.sv
`default_nettype none
// ============================================================================
// network_controller_if
// Weight-load / compute-request bus between the ROM controller and the neuron.
// Revision: 1.0
// ============================================================================
interface network_controller_if;
    logic        writeData;
    logic [1:0]  address;
    logic [0:31] rom_output;
    logic        start_network_controller;
    logic [0:31] inputs;
    logic        busy;
    logic        done;
    logic [0:25] result;
    logic        fire;
    logic [3:0]  loaded;
    logic        err;

    modport master (
        output writeData, address, rom_output, start_network_controller, inputs,
        input  busy, done, result, fire, loaded, err
    );

    modport slave (
        input  writeData, address, rom_output, start_network_controller, inputs,
        output busy, done, result, fire, loaded, err
    );
endinterface
`default_nettype wire

// File: rtl/network_controller.sv
`default_nettype none
// ============================================================================
// network_controller
// Four-weight signed MAC neuron fed by the ROM weight stream, with threshold fire.
// Revision: 1.0
// ============================================================================
module network_controller #(
    parameter logic signed [25:0] THRESHOLD = 26'sd0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    network_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic signed [25:0] acc_q, acc_d;
    logic signed [25:0] result_q, result_d;
    logic               fire_q, fire_d;
    logic               err_q, err_d;
    logic [3:0]         loaded_q, loaded_d;
    logic signed [15:0] weight_q [4];
    logic signed [15:0] weight_d [4];
    logic [0:31]        x_q, x_d;

    logic signed [7:0]  x_sel;
    logic signed [23:0] product;
    logic signed [25:0] acc_sum;
    logic               write_ok;
    logic               unused_rom_hi;

    assign unused_rom_hi = &{1'b0, bus.rom_output[0:15]};

    always_comb begin
        x_sel = 8'sd0;
        case (k_q)
            2'd0:    x_sel = x_q[0:7];
            2'd1:    x_sel = x_q[8:15];
            2'd2:    x_sel = x_q[16:23];
            default: x_sel = x_q[24:31];
        endcase
        product = weight_q[k_q] * x_sel;
        acc_sum = acc_q + {{2{product[23]}}, product};
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        x_d      = x_q;
        result_d = result_q;
        fire_d   = fire_q;
        err_d    = 1'b0;
        loaded_d = loaded_q;
        weight_d = weight_q;

        // A write landing on the same edge as a start must count toward the start check.
        write_ok = bus.writeData && (state_q != MAC);
        if (write_ok) begin
            weight_d[bus.address] = bus.rom_output[16:31];
            loaded_d[bus.address] = 1'b1;
        end

        case (state_q)
            MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d  = DONE;
                    result_d = acc_sum;
                    fire_d   = (acc_sum > THRESHOLD);
                end
            end
            default: begin
                state_d = IDLE;
                if (bus.start_network_controller) begin
                    if (loaded_d == 4'b1111) begin
                        state_d = MAC;
                        x_d     = bus.inputs;
                        acc_d   = 26'sd0;
                        k_d     = 2'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= 2'd0;
            acc_q    <= 26'sd0;
            x_q      <= 32'd0;
            result_q <= 26'sd0;
            fire_q   <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                weight_q[i] <= 16'sd0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            result_q <= result_d;
            fire_q   <= fire_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
            for (int i = 0; i < 4; i++) begin
                weight_q[i] <= weight_d[i];
            end
        end
    end

    assign bus.busy   = (state_q == MAC);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.fire   = fire_q;
    assign bus.loaded = loaded_q;
    assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_network_controller.sv
`default_nettype none
// ============================================================================
// tb_network_controller
// Directed and randomized checks of network_controller against a sum-of-products model.
// Revision: 1.0
// ============================================================================
module tb_network_controller;

    logic clk;
    logic rst;
    network_controller_if bus ();

    network_controller #(.THRESHOLD(26'sd0)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_w [4];
    logic [3:0]  m_loaded;
    logic [25:0] m_result;
    logic        m_fire;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_w[i] = 16'h0;
        m_loaded = 4'b0;
        m_result = 26'h0;
        m_fire   = 1'b0;
    endtask

    task automatic idle_bus();
        bus.writeData                = 1'b0;
        bus.address                  = 2'd0;
        bus.rom_output               = 32'h0;
        bus.start_network_controller = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy"},   64'(bus.busy),   64'(0));
        check_eq({tag, "_done"},   64'(bus.done),   64'(0));
        check_eq({tag, "_result"}, 64'(bus.result), 64'(0));
        check_eq({tag, "_fire"},   64'(bus.fire),   64'(0));
        check_eq({tag, "_err"},    64'(bus.err),    64'(0));
        check_eq({tag, "_loaded"}, 64'(bus.loaded), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check_reset_state("reset");
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.writeData  = 1'b1;
        bus.address    = a;
        bus.rom_output = {16'($urandom()), d};
        @(negedge clk);
        bus.writeData  = 1'b0;
        m_w[a]      = d;
        m_loaded[a] = 1'b1;
        check_eq("loaded", 64'(bus.loaded), 64'(m_loaded));
    endtask

    function automatic int mac_sum(input logic [31:0] in_v);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] xb;
            xb = in_v[31 - 8*k -: 8];
            s += int'($signed(m_w[k])) * int'($signed(xb));
        end
        return s;
    endfunction

    // mid: inject an ignored write of 0x7FFF to address 1 plus a stray start during MAC.
    // chain: leave the DUT sitting in DONE so the next start is issued from there.
    task automatic do_start(input logic [31:0] in_v, input bit same_wr, input logic [1:0] wa,
                            input logic [15:0] wd, input bit mid, input bit chain);
        int s;
        bus.start_network_controller = 1'b1;
        bus.inputs = in_v;
        if (same_wr) begin
            bus.writeData  = 1'b1;
            bus.address    = wa;
            bus.rom_output = {16'($urandom()), wd};
            m_w[wa]      = wd;
            m_loaded[wa] = 1'b1;
        end
        @(negedge clk);
        idle_bus();
        bus.inputs = $urandom();
        if (m_loaded == 4'b1111) begin
            s = mac_sum(in_v);
            for (int c = 0; c < 4; c++) begin
                check_eq("mac_busy", 64'(bus.busy), 64'(1));
                check_eq("mac_done", 64'(bus.done), 64'(0));
                if (mid && c == 1) begin
                    bus.writeData  = 1'b1;
                    bus.address    = 2'd1;
                    bus.rom_output = 32'h0000_7FFF;
                    bus.start_network_controller = 1'b1;
                end else begin
                    idle_bus();
                end
                @(negedge clk);
            end
            m_result = 26'(s);
            m_fire   = (s > 0);
            check_eq("done_pulse",  64'(bus.done),   64'(1));
            check_eq("done_busy",   64'(bus.busy),   64'(0));
            check_eq("done_err",    64'(bus.err),    64'(0));
            check_eq("result",      64'(bus.result), 64'(m_result));
            check_eq("fire",        64'(bus.fire),   64'(m_fire));
            if (!chain) begin
                @(negedge clk);
                check_eq("after_done", 64'(bus.done),   64'(0));
                check_eq("after_busy", 64'(bus.busy),   64'(0));
                check_eq("hold_result", 64'(bus.result), 64'(m_result));
            end
        end else begin
            check_eq("err_pulse",  64'(bus.err),    64'(1));
            check_eq("err_busy",   64'(bus.busy),   64'(0));
            check_eq("err_done",   64'(bus.done),   64'(0));
            @(negedge clk);
            check_eq("err_clear",  64'(bus.err),    64'(0));
            check_eq("err_done2",  64'(bus.done),   64'(0));
            check_eq("err_result", 64'(bus.result), 64'(m_result));
        end
    endtask

    task automatic load_all(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
        wr(2'd0, w0);
        wr(2'd1, w1);
        wr(2'd2, w2);
        wr(2'd3, w3);
    endtask

    initial begin
        rst = 1'b1;
        idle_bus();
        bus.inputs = 32'h0;
        model_clear();
        #2;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Basic MAC
        load_all(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        do_start(32'h0101_0101, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        check_eq("basic_result", 64'(bus.result), 64'(26'd10));

        // Negative sum
        load_all(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        do_start(32'h7F7F_7F7F, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        check_eq("neg_result", 64'(bus.result), 64'(26'h3FFFE04));

        // Extreme operands
        load_all(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        do_start(32'h8080_8080, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);
        check_eq("ext_result", 64'(bus.result), 64'(26'h1000000));

        // Incomplete load
        do_reset();
        wr(2'd0, 16'h0011);
        wr(2'd1, 16'h0022);
        wr(2'd2, 16'h0033);
        do_start(32'h0102_0304, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);

        // Same-edge write completes the load and is used by the MAC
        do_start(32'h0102_0304, 1'b1, 2'd3, 16'hFFF0, 1'b0, 1'b0);

        // Write and stray start during MAC are dropped
        load_all(16'h0005, 16'h0006, 16'hFFF9, 16'h0008);
        do_start(32'h0A0B_F00C, 1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        do_start(32'h0A0B_F00C, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);

        // Back-to-back start from DONE
        do_start(32'h1122_3344, 1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        do_start(32'h8899_AABB, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);

        // Reset mid-MAC
        bus.start_network_controller = 1'b1;
        bus.inputs = 32'h0505_0505;
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        do_start(32'h0505_0505, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            for (int j = 0; j < int'($urandom_range(0, 4)); j++)
                wr(2'($urandom_range(0, 3)), 16'($urandom()));
            do_start($urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     16'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
